reset_sequencer: RTL and testbench

- Parametrised power-on/soft reset sequencer that releases NUM_STAGES downstream reset domains one at a time, oldest stage first.
- Consecutive releases are spaced by a programmable gap. An optional per-stage ready handshake can gate each release, with a timeout fault.
- Sits at the top of the NN inference datapath. It drives the per-block resets (CORDIC units, layer engines, control) and a done flag for the host/top FSM.

---
 rtl/reset_sequencer_if.sv | 40 ++++
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_reset_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the sequencer's control and status signals.
//   sw_reset_req : single-cycle request to replay the whole release sequence
//   stage_ready  : per-stage ready-from-block (bit k-1 gates release of stage k)
//   rst_out      : active-high per-stage resets, bit 0 released first
//   complete     : all stages released and the final gap has elapsed
//   fault        : a stage_ready wait timed out
//   fault_stage  : index k-1 of the stage whose ready timed out
// The master modport is the sequencer side; slave is the host/block side.
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int FSW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
);
    logic                  sw_reset_req;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  complete;
    logic                  fault;
    logic [FSW-1:0]        fault_stage;

    modport master (
        input  sw_reset_req,
        input  stage_ready,
        output rst_out,
        output complete,
        output fault,
        output fault_stage
    );

    modport slave (
        output sw_reset_req,
        output stage_ready,
        input  rst_out,
        input  complete,
        input  fault,
        input  fault_stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Releases NUM_STAGES downstream reset domains one at a time (bit 0 first),
// spacing releases by GAP cycles, optionally gating each release on the
// previous stage's ready with a TIMEOUT fault, then raises complete GAP
// cycles after the last release.
// Ports:
//   clk         : system clock
//   ext_reset_n : asynchronous active-low reset (deassertion is synchronised)
//   bus         : reset_sequencer_if.master (sw_reset_req, stage_ready,
//                 rst_out, complete, fault, fault_stage)
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int GAP         = 10,
    parameter int SYNC_STAGES = 2,
    parameter int USE_READY   = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              ext_reset_n,
    reset_sequencer_if.master bus
);
    localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
    localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT - 1);

    // The release itself is an action on the transition edge rather than a
    // state of its own, so the GAP state is entered on the release edge with
    // cnt=0 and the next release lands exactly GAP edges later (works for GAP=1).
    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_GAP      = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_FINAL    = 3'd3,
        S_DONE     = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [CW-1:0]          r_cnt;
    logic [NUM_STAGES-1:0]  r_rst_out;
    logic                   r_complete;
    logic                   r_fault;
    logic [IW-1:0]          r_fault_stage;

    logic                   w_rst_sync_n;
    logic [IW-1:0]          w_next_idx;
    logic                   w_gap_end;
    logic                   w_to_end;
    logic                   w_ready;
    logic                   w_release;

    assign w_rst_sync_n = r_sync[SYNC_STAGES-1];
    assign w_next_idx   = r_idx + IW'(1'b1);
    assign w_gap_end    = (r_cnt == GAP_END);
    assign w_to_end     = (r_cnt == TO_END);
    // Without ready gating the release at gap expiry is unconditional.
    assign w_ready      = (USE_READY == 0) ? 1'b1 : bus.stage_ready[r_idx];
    assign w_release    = ((r_state == S_GAP) && w_gap_end && w_ready) ||
                          ((r_state == S_WAIT_RDY) && bus.stage_ready[r_idx]);

    // Reset-deassertion synchroniser: async clear, shifts in ones after release.
    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer FSM with registered outputs, reset by the synchronised reset.
    always_ff @(posedge clk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_state       <= S_HOLD;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_rst_out     <= '1;
            r_complete    <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else if (bus.sw_reset_req && (r_state != S_HOLD)) begin
            // Soft reset outranks ready and counter expiry on the same edge.
            r_state       <= S_HOLD;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_rst_out     <= '1;
            r_complete    <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_rst_out[0] <= 1'b0;
                    r_idx        <= '0;
                    r_cnt        <= '0;
                    r_state      <= (NUM_STAGES == 1) ? S_FINAL : S_GAP;
                end
                S_GAP, S_WAIT_RDY: begin
                    if (w_release) begin
                        r_idx                 <= w_next_idx;
                        r_rst_out[w_next_idx] <= 1'b0;
                        r_cnt                 <= '0;
                        r_state               <= (w_next_idx == LAST_IDX) ? S_FINAL : S_GAP;
                    end else if ((r_state == S_GAP) && w_gap_end) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RDY;
                    end else if ((r_state == S_WAIT_RDY) && w_to_end) begin
                        r_rst_out     <= '1;
                        r_fault       <= 1'b1;
                        r_fault_stage <= r_idx;
                        r_cnt         <= '0;
                        r_state       <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_FINAL: begin
                    if (w_gap_end) begin
                        r_complete <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_DONE, S_FAULT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state   <= S_HOLD;
                    r_idx     <= '0;
                    r_cnt     <= '0;
                    r_rst_out <= '1;
                end
            endcase
        end
    end

    assign bus.rst_out     = r_rst_out;
    assign bus.complete    = r_complete;
    assign bus.fault       = r_fault;
    assign bus.fault_stage = r_fault_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Three sequencers share clock, ext_reset_n and sw_reset_req:
//   A: NUM_STAGES=3, USE_READY=0   B: NUM_STAGES=3, USE_READY=1, TIMEOUT=64
//   C: NUM_STAGES=1
// Each run starts at an "origin" edge (first edge allowed to release stage 0).
// The reference model turns the origin, the ready rise edges and the edge of
// the next interruption into a list of output-change events, computed from
// release times: t0 = origin, t(k) = t(k-1)+GAP, delayed to the ready edge or
// turned into a fault after TIMEOUT.  A monitor pops one event per observed
// output change and compares the edge number and output values.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;
    localparam int GAP   = 10;
    localparam int TO    = 64;
    localparam int NEVER = 1000000;

    typedef struct packed {
        logic [2:0] rst;
        logic       cmpl;
        logic       flt;
        logic [1:0] fst;
    } outs_t;

    typedef struct {
        int    edge_n;
        outs_t o;
    } evt_t;

    logic clk;
    logic ext_reset_n;

    reset_sequencer_if #(.NUM_STAGES(3)) bus_a ();
    reset_sequencer_if #(.NUM_STAGES(3)) bus_b ();
    reset_sequencer_if #(.NUM_STAGES(1)) bus_c ();

    reset_sequencer #(.NUM_STAGES(3), .GAP(GAP), .SYNC_STAGES(2), .USE_READY(0), .TIMEOUT(TO))
        dut_a (.clk(clk), .ext_reset_n(ext_reset_n), .bus(bus_a));
    reset_sequencer #(.NUM_STAGES(3), .GAP(GAP), .SYNC_STAGES(2), .USE_READY(1), .TIMEOUT(TO))
        dut_b (.clk(clk), .ext_reset_n(ext_reset_n), .bus(bus_b));
    reset_sequencer #(.NUM_STAGES(1), .GAP(GAP), .SYNC_STAGES(2), .USE_READY(0), .TIMEOUT(TO))
        dut_c (.clk(clk), .ext_reset_n(ext_reset_n), .bus(bus_c));

    int    edge_n   = -1;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cur_a0;
    int    cur_a1;
    bit    mon_on   = 1'b0;
    outs_t prev [3];
    evt_t  qa [$];
    evt_t  qb [$];
    evt_t  qc [$];

    // Clock: edge 0 at t=5, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: first rising edge is edge 0.
    initial begin
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
        end
    end

    function automatic logic [2:0] full_of(int id);
        return (id == 2) ? 3'b001 : 3'b111;
    endfunction

    function automatic outs_t sample(int id);
        outs_t s;
        case (id)
            0:       s = outs_t'({bus_a.rst_out, bus_a.complete, bus_a.fault, bus_a.fault_stage});
            1:       s = outs_t'({bus_b.rst_out, bus_b.complete, bus_b.fault, bus_b.fault_stage});
            default: s = outs_t'({2'b00, bus_c.rst_out, bus_c.complete, bus_c.fault, 1'b0, bus_c.fault_stage});
        endcase
        return s;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("rst=%b complete=%b fault=%b fault_stage=%0d", o.rst, o.cmpl, o.flt, o.fst);
    endfunction

    task automatic compare(string name, int ge, outs_t got, int ee, outs_t exp);
        n_checks++;
        if ((got === exp) && (ge == ee)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got edge %0d %s, required edge %0d %s",
                     name, ge, fmt(got), ee, fmt(exp));
        end
    endtask

    task automatic push_evt(int id, int e, outs_t o);
        evt_t ev;
        ev.edge_n = e;
        ev.o      = o;
        case (id)
            0:       qa.push_back(ev);
            1:       qb.push_back(ev);
            default: qc.push_back(ev);
        endcase
    endtask

    // Reference model for one run: events strictly before edge x are queued.
    task automatic push_run(int id, int o, int x, int a0, int a1);
        int    n   = (id == 2) ? 1 : 3;
        bit    usr = (id == 1);
        outs_t v;
        int    t, e, ak, nt;
        v.rst  = full_of(id);
        v.rst[0] = 1'b0;
        v.cmpl = 1'b0;
        v.flt  = 1'b0;
        v.fst  = 2'd0;
        if (o < x) push_evt(id, o, v);
        t = o;
        for (int k = 1; k < n; k++) begin
            e  = t + GAP;
            ak = (k == 1) ? a0 : a1;
            // ready raised after edge ak is first seen on edge ak+1
            if (!usr || (ak + 1 <= e)) begin
                nt = e;
            end else if (ak + 1 <= e + TO) begin
                nt = ak + 1;
            end else begin
                outs_t f;
                f.rst  = full_of(id);
                f.cmpl = 1'b0;
                f.flt  = 1'b1;
                f.fst  = 2'(k - 1);
                if (e + TO < x) push_evt(id, e + TO, f);
                return;
            end
            t = nt;
            v.rst[k] = 1'b0;
            if (t < x) push_evt(id, t, v);
        end
        v.cmpl = 1'b1;
        if (t + GAP < x) push_evt(id, t + GAP, v);
    endtask

    task automatic take(int id, int e, outs_t got);
        evt_t ev;
        bit   have = 1'b0;
        case (id)
            0:       if (qa.size() > 0) begin ev = qa.pop_front(); have = 1'b1; end
            1:       if (qb.size() > 0) begin ev = qb.pop_front(); have = 1'b1; end
            default: if (qc.size() > 0) begin ev = qc.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
            compare($sformatf("event_dut%0d", id), e, got, ev.edge_n, ev.o);
        end else begin
            n_checks++;
            $display("FAIL unexpected_change_dut%0d: got edge %0d %s, required no change",
                     id, e, fmt(got));
        end
    endtask

    // Monitor: every output change on any DUT is matched against its queue.
    initial begin
        outs_t cur;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                for (int id = 0; id < 3; id++) begin
                    cur = sample(id);
                    if (cur !== prev[id]) begin
                        take(id, edge_n, cur);
                        prev[id] = cur;
                    end
                end
            end
        end
    end

    task automatic apply_ready();
        if (edge_n == cur_a0) bus_b.stage_ready[0] = 1'b1;
        if (edge_n == cur_a1) bus_b.stage_ready[1] = 1'b1;
        bus_b.stage_ready[2] = 1'($urandom);
        bus_a.stage_ready    = 3'($urandom);
        bus_c.stage_ready    = 1'($urandom);
    endtask

    task automatic wait_to_edge(int target);
        while (edge_n < target) begin
            @(posedge clk);
            #1;
            apply_ready();
        end
    endtask

    function automatic int pick_ready(int base);
        return ($urandom_range(0, 3) == 0) ? NEVER : base + $urandom_range(0, 100);
    endfunction

    // One run from origin o, interrupted at edge x by a soft reset (kind 0)
    // or by ext_reset_n dropping just after edge x for `hold` edges (kind 1).
    task automatic step(int o, int kind, int x, int hold, int na0, int na1, output int no);
        outs_t r;
        for (int id = 0; id < 3; id++) begin
            push_run(id, o, x, cur_a0, cur_a1);
            r.rst  = full_of(id);
            r.cmpl = 1'b0;
            r.flt  = 1'b0;
            r.fst  = 2'd0;
            push_evt(id, x, r);
        end
        if (kind == 0) begin
            wait_to_edge(x - 1);
            bus_a.sw_reset_req = 1'b1;
            bus_b.sw_reset_req = 1'b1;
            bus_c.sw_reset_req = 1'b1;
            wait_to_edge(x);
            bus_a.sw_reset_req = 1'b0;
            bus_b.sw_reset_req = 1'b0;
            bus_c.sw_reset_req = 1'b0;
            cur_a0 = na0;
            cur_a1 = na1;
            bus_b.stage_ready[1:0] = 2'b00;
            apply_ready();
            no = x + 1;
        end else begin
            wait_to_edge(x);
            ext_reset_n = 1'b0;
            #1;
            for (int id = 0; id < 3; id++) begin
                r.rst  = full_of(id);
                r.cmpl = 1'b0;
                r.flt  = 1'b0;
                r.fst  = 2'd0;
                compare($sformatf("async_assert_dut%0d", id), edge_n, sample(id), edge_n, r);
            end
            cur_a0 = na0;
            cur_a1 = na1;
            bus_b.stage_ready[1:0] = 2'b00;
            apply_ready();
            wait_to_edge(x + hold);
            ext_reset_n = 1'b1;
            no = x + hold + 3;
        end
    endtask

    initial begin
        int    o, no, x, kind, hold;
        outs_t r;
        ext_reset_n        = 1'b1;
        bus_a.sw_reset_req = 1'b0;
        bus_b.sw_reset_req = 1'b0;
        bus_c.sw_reset_req = 1'b0;
        bus_a.stage_ready  = 3'b000;
        bus_b.stage_ready  = 3'b000;
        bus_c.stage_ready  = 1'b0;
        #1;
        ext_reset_n = 1'b0;
        cur_a0 = 20;
        cur_a1 = 0;

        // Reset state, checked just after edge 0 while ext_reset_n is still low.
        @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            r.rst  = full_of(id);
            r.cmpl = 1'b0;
            r.flt  = 1'b0;
            r.fst  = 2'd0;
            compare($sformatf("reset_state_dut%0d", id), edge_n, sample(id), 0, r);
            prev[id] = r;
        end
        ext_reset_n = 1'b1;
        apply_ready();
        mon_on = 1'b1;
        o = 3;

        // Power-on run (B gated by stage_ready[0] rising after edge 20).
        step(o, 0, 45, 0, 45, NEVER, no);
        o = no;
        // B times out waiting for stage_ready[1]; soft reset clears the fault.
        step(o, 0, 140, 0, 140, 140, no);
        o = no;
        // Soft reset on the same edge the first gap expires with ready high.
        step(o, 0, o + GAP, 0, o + GAP, o + GAP, no);
        o = no;
        // Asynchronous abort mid-sequence.
        x = o + 12;
        step(o, 1, x, 5, pick_ready(x), pick_ready(x), no);
        o = no;

        for (int i = 0; i < 10; i++) begin
            kind = int'($urandom_range(0, 1));
            x    = o + (($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 60))
                                                    : int'($urandom_range(140, 180)));
            hold = int'($urandom_range(1, 4));
            step(o, kind, x, hold, pick_ready(x), pick_ready(x), no);
            o = no;
        end

        // Final run left to settle; nothing may remain outstanding.
        for (int id = 0; id < 3; id++) push_run(id, o, o + 200, cur_a0, cur_a1);
        wait_to_edge(o + 200);
        @(negedge clk);
        n_checks++;
        if (qa.size() == 0) n_pass++;
        else $display("FAIL pending_dut0: got %0d outstanding events, required 0", qa.size());
        n_checks++;
        if (qb.size() == 0) n_pass++;
        else $display("FAIL pending_dut1: got %0d outstanding events, required 0", qb.size());
        n_checks++;
        if (qc.size() == 0) n_pass++;
        else $display("FAIL pending_dut2: got %0d outstanding events, required 0", qc.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
